ram_copy_master: RTL

Bus initiator that copies a block of 32-bit words from one address range to another over the valid/ready memory handshake used by the on-chip RAM and other peripherals. It sits on the master side of the bus, beside the core, and drives the same request/response signals that the RAM slave consumes. One transaction is outstanding at a time. Each word is read, then written, with full handshakes on both the request phase and the response phase.

---
 rtl/ram_copy_master_if.sv | 22 ++
 rtl/ram_copy_master.sv | 117 +++++++++++
 2 files changed

// File: rtl/ram_copy_master_if.sv
// rtl/ram_copy_master_if.sv - valid/ready memory bus between the copy master and a RAM slave
interface ram_copy_master_if;
  logic [31:0] addr_o;
  logic [31:0] data_o;
  logic [3:0]  sel_o;
  logic        we_o;
  logic        req_valid_o;
  logic        rsp_ready_o;
  logic [31:0] data_i;
  logic        req_ready_i;
  logic        rsp_valid_i;

  modport master (
    output addr_o, data_o, sel_o, we_o, req_valid_o, rsp_ready_o,
    input  data_i, req_ready_i, rsp_valid_i
  );

  modport slave (
    input  addr_o, data_o, sel_o, we_o, req_valid_o, rsp_ready_o,
    output data_i, req_ready_i, rsp_valid_i
  );
endinterface

// File: rtl/ram_copy_master.sv
// rtl/ram_copy_master.sv - word-by-word read-then-write block copy initiator, one transaction outstanding
module ram_copy_master #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [31:0]      src_addr_i,
  input  logic [31:0]      dst_addr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  ram_copy_master_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_REQ = 3'd1,
    RD_RSP = 3'd2,
    WR_REQ = 3'd3,
    WR_RSP = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [LEN_W-1:0] rem_q;
  logic [31:0]      buf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start_i && (len_i != '0)) begin
            src_q <= src_addr_i & 32'hFFFF_FFFC;
            dst_q <= dst_addr_i & 32'hFFFF_FFFC;
            rem_q <= len_i;
          end
        end
        RD_RSP: begin
          if (bus.rsp_valid_i) buf_q <= bus.data_i;
        end
        WR_RSP: begin
          // addresses wrap naturally modulo 2^32
          if (bus.rsp_valid_i) begin
            src_q <= src_q + 32'd4;
            dst_q <= dst_q + 32'd4;
            rem_q <= rem_q - LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from registered state only, so the request fields stay frozen through any stall.
  always_comb begin
    state_d         = state_q;
    busy_o          = 1'b0;
    done_o          = 1'b0;
    bus.addr_o      = '0;
    bus.data_o      = '0;
    bus.sel_o       = '0;
    bus.we_o        = 1'b0;
    bus.req_valid_o = 1'b0;
    bus.rsp_ready_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = (len_i != '0) ? RD_REQ : DONE;
      end
      RD_REQ: begin
        busy_o          = 1'b1;
        bus.req_valid_o = 1'b1;
        bus.addr_o      = src_q;
        if (bus.req_ready_i) state_d = RD_RSP;
      end
      RD_RSP: begin
        busy_o          = 1'b1;
        bus.rsp_ready_o = 1'b1;
        bus.addr_o      = src_q;
        if (bus.rsp_valid_i) state_d = WR_REQ;
      end
      WR_REQ: begin
        busy_o          = 1'b1;
        bus.req_valid_o = 1'b1;
        bus.we_o        = 1'b1;
        bus.sel_o       = 4'hF;
        bus.addr_o      = dst_q;
        bus.data_o      = buf_q;
        if (bus.req_ready_i) state_d = WR_RSP;
      end
      WR_RSP: begin
        busy_o          = 1'b1;
        bus.rsp_ready_o = 1'b1;
        bus.we_o        = 1'b1;
        bus.sel_o       = 4'hF;
        bus.addr_o      = dst_q;
        bus.data_o      = buf_q;
        if (bus.rsp_valid_i) state_d = (rem_q == LEN_W'(1)) ? DONE : RD_REQ;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
